// File: rtl/vend_txn_sequencer_if.sv
// rtl/vend_txn_sequencer_if.sv - request, table and command bus of the vend transaction sequencer
//
// Purpose: bundles every sequencer signal except clock and reset.
// Ports (by group):
//   request  : mode, reqValid, reqReady, productCode, productCount
//   table    : tableAddr, priceRdData, stockRdData, customerMoney
//   commands : debitValid/debitReady/debitAmount, stockDecValid/stockDecReady/stockDecCount
//   result   : doneValid, status, isError
// Modports: master = environment (request source, tables, stores), slave = sequencer.
interface vend_txn_sequencer_if #(
    parameter int CODE_W = 3,
    parameter int VAL_W  = 4
);
    logic [2:0]        mode;
    logic              reqValid;
    logic              reqReady;
    logic [CODE_W-1:0] productCode;
    logic [VAL_W-1:0]  productCount;
    logic [CODE_W-1:0] tableAddr;
    logic [VAL_W-1:0]  priceRdData;
    logic [VAL_W-1:0]  stockRdData;
    logic [VAL_W-1:0]  customerMoney;
    logic              debitValid;
    logic              debitReady;
    logic [VAL_W-1:0]  debitAmount;
    logic              stockDecValid;
    logic              stockDecReady;
    logic [VAL_W-1:0]  stockDecCount;
    logic              doneValid;
    logic [2:0]        status;
    logic              isError;

    modport master (
        output mode, reqValid, productCode, productCount,
        output priceRdData, stockRdData, customerMoney,
        output debitReady, stockDecReady,
        input  reqReady, tableAddr, debitValid, debitAmount,
        input  stockDecValid, stockDecCount, doneValid, status, isError
    );

    modport slave (
        input  mode, reqValid, productCode, productCount,
        input  priceRdData, stockRdData, customerMoney,
        input  debitReady, stockDecReady,
        output reqReady, tableAddr, debitValid, debitAmount,
        output stockDecValid, stockDecCount, doneValid, status, isError
    );
endinterface

// File: rtl/vend_txn_sequencer.sv
// rtl/vend_txn_sequencer.sv - buy-transaction sequencer: lookup, check, commit, report
//
// Purpose: accepts a buy request, reads price/stock for the product, checks
// quantity/stock/funds, then issues debit and stock-decrement commands and
// reports a one-cycle doneValid with a status code.
// Ports:
//   mainClock : rising-edge clock
//   resetN    : asynchronous active-low reset
//   bus       : vend_txn_sequencer_if.slave (request, table, command, result groups)
// Status codes: 0 OK, 1 zero count, 2 short stock, 3 short funds, 4 commit timeout.
module vend_txn_sequencer #(
    parameter int CODE_W  = 3,
    parameter int VAL_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 mainClock,
    input  logic                 resetN,
    vend_txn_sequencer_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_ZERO    = 3'b001;
    localparam logic [2:0] ST_STOCK   = 3'b010;
    localparam logic [2:0] ST_FUNDS   = 3'b011;
    localparam logic [2:0] ST_TIMEOUT = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } stateType;

    stateType          state;
    logic [VAL_W-1:0]  countReg;
    logic [CNT_W-1:0]  commitCnt;

    logic [2*VAL_W-1:0] cost;
    logic [2:0]         checkStatus;
    logic               debitFin;
    logic               stockFin;
    logic               timeUp;

    // Full-width product so an overflowing cost can never alias to an affordable one.
    assign cost = (2*VAL_W)'(bus.priceRdData) * (2*VAL_W)'(countReg);

    always_comb begin
        checkStatus = ST_OK;
        if (countReg == '0) begin
            checkStatus = ST_ZERO;
        end else if (countReg > bus.stockRdData) begin
            checkStatus = ST_STOCK;
        end else if (cost > {{VAL_W{1'b0}}, bus.customerMoney}) begin
            checkStatus = ST_FUNDS;
        end
    end

    // A command is finished once its valid is low or it handshakes this cycle.
    assign debitFin = !bus.debitValid || bus.debitReady;
    assign stockFin = !bus.stockDecValid || bus.stockDecReady;
    assign timeUp   = (commitCnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge mainClock or negedge resetN) begin
        if (!resetN) begin
            state             <= IDLE;
            countReg          <= '0;
            commitCnt         <= '0;
            bus.reqReady      <= 1'b0;
            bus.tableAddr     <= '0;
            bus.debitValid    <= 1'b0;
            bus.stockDecValid <= 1'b0;
            bus.debitAmount   <= '0;
            bus.stockDecCount <= '0;
            bus.doneValid     <= 1'b0;
            bus.status        <= ST_OK;
            bus.isError       <= 1'b0;
        end else begin
            bus.doneValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.reqValid && bus.reqReady && (bus.mode == 3'b000)) begin
                        // tableAddr doubles as the latched product code.
                        bus.tableAddr <= bus.productCode;
                        countReg      <= bus.productCount;
                        bus.reqReady  <= 1'b0;
                        bus.isError   <= 1'b0;
                        state         <= LOOKUP;
                    end else begin
                        bus.reqReady <= 1'b1;
                    end
                end

                LOOKUP: begin
                    bus.tableAddr <= '0;
                    state         <= CHECK;
                end

                CHECK: begin
                    if (checkStatus != ST_OK) begin
                        bus.status    <= checkStatus;
                        bus.isError   <= 1'b1;
                        bus.doneValid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        bus.debitAmount   <= cost[VAL_W-1:0];
                        bus.stockDecCount <= countReg;
                        bus.debitValid    <= 1'b1;
                        bus.stockDecValid <= 1'b1;
                        commitCnt         <= '0;
                        state             <= COMMIT;
                    end
                end

                COMMIT: begin
                    if (bus.debitValid && bus.debitReady) begin
                        bus.debitValid <= 1'b0;
                    end
                    if (bus.stockDecValid && bus.stockDecReady) begin
                        bus.stockDecValid <= 1'b0;
                    end
                    // Completion on the last allowed cycle still counts as OK.
                    if (debitFin && stockFin) begin
                        bus.status    <= ST_OK;
                        bus.isError   <= 1'b0;
                        bus.doneValid <= 1'b1;
                        state         <= DONE;
                    end else if (timeUp) begin
                        bus.debitValid    <= 1'b0;
                        bus.stockDecValid <= 1'b0;
                        bus.status        <= ST_TIMEOUT;
                        bus.isError       <= 1'b1;
                        bus.doneValid     <= 1'b1;
                        state             <= DONE;
                    end else begin
                        commitCnt <= commitCnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    bus.reqReady <= 1'b1;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vend_txn_sequencer.sv
// tb/tb_vend_txn_sequencer.sv - directed self-checking bench for vend_txn_sequencer
module tb_vend_txn_sequencer;
    logic mainClock;
    logic resetN;
    int   total;
    int   bad;
    logic [3:0] priceTab [8];
    logic [3:0] stockTab [8];
    logic [2:0] lastStatus;
    logic       lastErr;

    vend_txn_sequencer_if #(.CODE_W(3), .VAL_W(4)) bus ();

    vend_txn_sequencer #(.CODE_W(3), .VAL_W(4), .TIMEOUT(15)) dut (
        .mainClock (mainClock),
        .resetN    (resetN),
        .bus       (bus.slave)
    );

    initial mainClock = 1'b0;
    always #5 mainClock = ~mainClock;

    // Synchronous price/stock table: data valid one cycle after the address.
    always @(posedge mainClock) begin
        bus.priceRdData <= priceTab[bus.tableAddr];
        bus.stockRdData <= stockTab[bus.tableAddr];
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic logic [18:0] allOutputs();
        return {bus.reqReady, bus.tableAddr, bus.debitValid, bus.stockDecValid,
                bus.debitAmount, bus.stockDecCount, bus.doneValid, bus.status, bus.isError};
    endfunction

    // Called just after a negedge; returns just after a negedge with the DUT idle.
    // dN/sN: COMMIT cycle (1-based) from which the ready is high, 0 = never.
    task automatic runTxn(input string tag, input logic [2:0] code, input logic [3:0] cnt,
                          input logic [3:0] money, input int dN, input int sN,
                          input int expDone, input logic [2:0] expStatus,
                          input int expDHs, input int expAmt, input int expSHs, input int expCnt,
                          input int expDLast, input int expSLast);
        int doneCycle, doneCount, dHs, sHs, dLast, sLast, amt, sc;
        doneCycle = 0; doneCount = 0; dHs = 0; sHs = 0; dLast = 0; sLast = 0; amt = 0; sc = 0;
        checkValue({tag, "/c0_ready"}, 32'(bus.reqReady), 1);
        checkValue({tag, "/c0_status_held"}, 32'(bus.status), 32'(lastStatus));
        checkValue({tag, "/c0_err_sticky"}, 32'(bus.isError), 32'(lastErr));
        bus.mode = 3'b000;
        bus.reqValid = 1'b1;
        bus.productCode = code;
        bus.productCount = cnt;
        bus.customerMoney = money;
        @(posedge mainClock);
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge mainClock);
            if (cyc == 1) begin
                bus.reqValid = 1'b0;
                bus.mode = 3'b101;
                checkValue({tag, "/c1_addr"}, 32'(bus.tableAddr), 32'(code));
                checkValue({tag, "/c1_ready"}, 32'(bus.reqReady), 0);
                checkValue({tag, "/c1_err_clr"}, 32'(bus.isError), 0);
            end
            bus.debitReady = (dN != 0) && (cyc >= 2 + dN);
            bus.stockDecReady = (sN != 0) && (cyc >= 2 + sN);
            if (bus.doneValid) begin
                doneCount++;
                if (doneCycle == 0) begin
                    doneCycle = cyc;
                    checkValue({tag, "/status"}, 32'(bus.status), 32'(expStatus));
                    checkValue({tag, "/isError"}, 32'(bus.isError), 32'(expStatus != 3'b000));
                end
            end
            if (bus.debitValid) dLast = cyc;
            if (bus.stockDecValid) sLast = cyc;
            if (bus.debitValid && bus.debitReady) begin dHs++; amt = bus.debitAmount; end
            if (bus.stockDecValid && bus.stockDecReady) begin sHs++; sc = bus.stockDecCount; end
        end
        checkValue({tag, "/done_cycle"}, doneCycle, expDone);
        checkValue({tag, "/done_pulses"}, doneCount, 1);
        checkValue({tag, "/debit_hs"}, dHs, expDHs);
        checkValue({tag, "/stock_hs"}, sHs, expSHs);
        checkValue({tag, "/debit_last"}, dLast, expDLast);
        checkValue({tag, "/stock_last"}, sLast, expSLast);
        if (expDHs != 0) checkValue({tag, "/debit_amt"}, amt, expAmt);
        if (expSHs != 0) checkValue({tag, "/stock_cnt"}, sc, expCnt);
        lastStatus = expStatus;
        lastErr = (expStatus != 3'b000);
        bus.mode = 3'b000;
        bus.debitReady = 1'b0;
        bus.stockDecReady = 1'b0;
    endtask

    initial begin
        int sawDone;
        total = 0; bad = 0;
        lastStatus = 3'b000; lastErr = 1'b0;
        for (int i = 0; i < 8; i++) begin priceTab[i] = 4'd1; stockTab[i] = 4'd9; end
        priceTab[2] = 4'd2; stockTab[2] = 4'd5;
        priceTab[1] = 4'd1; stockTab[1] = 4'd3;
        priceTab[3] = 4'd5; stockTab[3] = 4'd9;
        priceTab[4] = 4'd3; stockTab[4] = 4'd5;
        priceTab[5] = 4'd1; stockTab[5] = 4'd9;
        bus.mode = 3'b000; bus.reqValid = 1'b0; bus.productCode = '0; bus.productCount = '0;
        bus.customerMoney = '0; bus.debitReady = 1'b0; bus.stockDecReady = 1'b0;

        resetN = 1'b0;
        #3;
        checkValue("reset_outputs", 32'(allOutputs()), 0);
        @(negedge mainClock);
        @(negedge mainClock);
        checkValue("reset_ready_low", 32'(bus.reqReady), 0);
        resetN = 1'b1;
        @(negedge mainClock);
        checkValue("ready_after_reset", 32'(bus.reqReady), 1);

        //     tag       code cnt money dN sN done st      dHs amt sHs cnt dLast sLast
        runTxn("ok",      3'd2, 4'd3, 4'd9,  1, 1, 4,  3'b000, 1, 6,  1, 3, 3, 3);
        runTxn("stock",   3'd1, 4'd4, 4'd15, 1, 1, 3,  3'b010, 0, 0,  0, 0, 0, 0);
        runTxn("funds",   3'd3, 4'd4, 4'd15, 1, 1, 3,  3'b011, 0, 0,  0, 0, 0, 0);
        runTxn("zero",    3'd5, 4'd0, 4'd15, 1, 1, 3,  3'b001, 0, 0,  0, 0, 0, 0);
        runTxn("exact",   3'd4, 4'd5, 4'd15, 1, 1, 4,  3'b000, 1, 15, 1, 5, 3, 3);
        runTxn("timeout", 3'd5, 4'd2, 4'd15, 1, 0, 18, 3'b100, 1, 2,  0, 0, 3, 17);
        runTxn("stagger", 3'd5, 4'd2, 4'd15, 1, 3, 6,  3'b000, 1, 2,  1, 2, 3, 5);

        // Wrong mode: request must be ignored.
        bus.mode = 3'b010; bus.reqValid = 1'b1; bus.productCode = 3'd2; bus.productCount = 4'd1;
        sawDone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mainClock);
            if (bus.doneValid || bus.tableAddr != 3'd0) sawDone++;
        end
        checkValue("mode_not_accepted", sawDone, 0);
        checkValue("mode_still_ready", 32'(bus.reqReady), 1);
        bus.reqValid = 1'b0; bus.mode = 3'b000;

        // Reset while in COMMIT: immediate zero outputs, no doneValid.
        bus.reqValid = 1'b1; bus.productCode = 3'd5; bus.productCount = 4'd2; bus.customerMoney = 4'd15;
        @(posedge mainClock);
        @(negedge mainClock);
        bus.reqValid = 1'b0;
        @(negedge mainClock);
        @(negedge mainClock);
        checkValue("commit_reached", 32'(bus.debitValid), 1);
        #2;
        resetN = 1'b0;
        #1;
        checkValue("async_reset_outputs", 32'(allOutputs()), 0);
        sawDone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mainClock);
            if (bus.doneValid) sawDone++;
        end
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge mainClock);
            if (bus.doneValid) sawDone++;
        end
        checkValue("no_done_after_reset", sawDone, 0);
        checkValue("ready_after_commit_reset", 32'(bus.reqReady), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vend_txn_sequencer.md
VEND_TXN_SEQUENCER -- requirements
Module: vend_txn_sequencer

Interface
REQ-001 SHALL provide parameter CODE_W, default 3, meaning product code width (8 products).
REQ-002 SHALL provide parameter VAL_W, default 4, meaning width of count, price, stock and money values.
REQ-003 SHALL provide parameter TIMEOUT, default 15, meaning the maximum number of COMMIT cycles before abort.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 SHALL have port mainClock  in  1  rising-edge clock.
REQ-006 SHALL have port resetN  in  1  asynchronous active-low reset.
REQ-007 SHALL have port mode  in  3  machine mode; requests are accepted only when mode=3'b000 (buy).
REQ-008 SHALL have port reqValid  in  1  buy request present.
REQ-009 SHALL have port reqReady  out  1  sequencer can accept a request.
REQ-010 SHALL have port productCode  in  CODE_W  product to buy.
REQ-011 SHALL have port productCount  in  VAL_W  quantity to buy.
REQ-012 SHALL have port tableAddr  out  CODE_W  price/stock table read address.
REQ-013 SHALL have port priceRdData  in  VAL_W  unit price, valid 1 cycle after tableAddr is driven.
REQ-014 SHALL have port stockRdData  in  VAL_W  stock level, valid 1 cycle after tableAddr is driven.
REQ-015 SHALL have port customerMoney  in  VAL_W  current customer balance.
REQ-016 SHALL have port debitValid  out  1  debit command to the money store.
REQ-017 SHALL have port debitReady  in  1  money store accepts the debit.
REQ-018 SHALL have port debitAmount  out  VAL_W  amount to move from the customer to the machine.
REQ-019 SHALL have port stockDecValid  out  1  stock decrement command.
REQ-020 SHALL have port stockDecReady  in  1  stock store accepts the decrement.
REQ-021 SHALL have port stockDecCount  out  VAL_W  units to remove.
REQ-022 SHALL have port doneValid  out  1  one-cycle transaction-complete pulse.
REQ-023 SHALL have port status  out  3  result code, held until the next doneValid.
REQ-024 SHALL have port isError  out  1  status!=0, sticky until the next accepted request.

Function
REQ-025 SHALL implement states IDLE, LOOKUP, CHECK, COMMIT and DONE.
REQ-026 SHALL drive reqReady=1 only in IDLE; a request is accepted when reqValid&reqReady&(mode==3'b000), latching productCode and productCount, and the FSM moves to LOOKUP.
REQ-027 SHALL, in LOOKUP, drive tableAddr with the latched code for exactly 1 cycle and then move to CHECK.
REQ-028 SHALL, in CHECK, compute cost=price*count at 2*VAL_W bits with no truncation and choose the first matching status: count==0 -> 3'b001; count>stock -> 3'b010; cost>customerMoney -> 3'b011; otherwise OK 3'b000.
REQ-029 SHALL go CHECK->DONE on any nonzero status, with no command asserted; on OK it SHALL go CHECK->COMMIT, registering debitAmount=cost[VAL_W-1:0] and stockDecCount=count.
REQ-030 SHALL, in COMMIT, assert debitValid and stockDecValid together on the first cycle; each SHALL drop independently the cycle after its own valid&ready handshake, and data SHALL stay stable while valid is high.
REQ-031 SHALL go COMMIT->DONE with status OK once both handshakes have completed, including when both complete in the same cycle.
REQ-032 SHALL count COMMIT cycles; if both handshakes are not complete after TIMEOUT cycles, it SHALL drop both valids, set status 3'b100 and go to DONE (completed commands are not rolled back).
REQ-033 SHALL assert doneValid for 1 cycle in DONE, update status and isError in that cycle, and return to IDLE.
REQ-034 SHALL give a minimum latency of 4 cycles from accept to doneValid on OK with both readies high, and 3 cycles on a CHECK error.
REQ-035 SHALL ignore mode changes after a request has been accepted; the transaction completes.
REQ-036 SHALL clear isError on request accept.

Reset
REQ-037 SHALL, while resetN=0 (asynchronous), force state IDLE and drive reqReady=0, tableAddr=0, debitValid=0, stockDecValid=0, debitAmount=0, stockDecCount=0, doneValid=0, status=0, isError=0, and clear the timeout counter.
REQ-038 SHALL drive reqReady=1 on the first clock edge after resetN rises; a reset during COMMIT SHALL abort the transaction with no doneValid and no rollback.

Verification
REQ-039 SHALL verify: code=2, count=3, price=2, stock=5, money=9, readies high -> debitAmount=6 and stockDecCount=3 handshaked, doneValid 4 cycles after accept, status=0.
REQ-040 SHALL verify: count=4, stock=3 -> no valids asserted, doneValid 3 cycles after accept, status=3'b010, isError=1.
REQ-041 SHALL verify: price=5, count=4, money=15 (cost=20 exceeds 4 bits) -> status=3'b011, no debit.
REQ-042 SHALL verify: debitReady high, stockDecReady low for 15 cycles -> debit done, stockDecValid dropped, status=3'b100.
REQ-043 SHALL verify: readies staggered (debit at COMMIT cycle 1, stock at COMMIT cycle 3) -> debitValid falls after cycle 1, doneValid follows cycle 3, status=0.
REQ-044 SHALL verify: reqValid=1 with mode=3'b010 -> not accepted; resetN pulsed low in COMMIT -> all outputs 0 immediately, no doneValid.
